line_buffer_3row: RTL and testbench
===================================

// Module: line_buffer_3row
// PURPOSE
//  Upstream stage of the 3x3 convolution unit. Accepts a raster-scan pixel stream, one pixel per beat.
//  For each accepted pixel, presents a vertical 3-pixel column: current row plus the two rows above.
//  Output rate equals input rate: exactly IMG_W*IMG_H columns per frame, in the order the conv unit counts them.
//  Two line memories hold rows r-1 and r-2; rows above the image top are zero-filled.
// PARAMETERS
//  IMG_W  640  pixels per row
//  IMG_H  480  rows per frame
//  PIX_W  8    bits per pixel, unsigned
// PORTS
//  clk_i    in   1            clock, all logic on posedge
//  reset_i  in   1            synchronous, active-high reset
//  pix_i    in   PIX_W        input pixel, raster order
//  v_i      in   1            pix_i valid
//  ready_o  out  1            block can accept pix_i this cycle
//  data_o   out  [2:0][PIX_W] [0]=row r, [1]=row r-1, [2]=row r-2, same column c
//  v_o      out  1            data_o valid
//  ready_i  in   1            downstream accepts data_o this cycle
//  last_o   out  1            data_o is column (IMG_H-1, IMG_W-1); qualified by v_o
// BEHAVIOUR
//  - Reset (reset_i=1 at posedge): v_o=0, data_o=0, last_o=0, row/col counters=0. ready_o=1 on the first cycle after reset.
//  - Line memory contents are not reset; stale data is masked by the zero-fill rule.
//  - Accept: acc = v_i & ready_o. Output hold: hold = v_o & ~ready_i.
//  - ready_o = ~v_o | ready_i (single output register, no skid); combinational path ready_i -> ready_o.
//  - On acc at (r,c), registered onto data_o on the same edge (latency 1 cycle):
//      data_o[0]=pix_i; data_o[1]=(r>=1)?lb1[c]:0; data_o[2]=(r>=2)?lb2[c]:0.
//  - Same edge: lb2[c]<=lb1[c]; lb1[c]<=pix_i. Memory is read-before-write at a single address c.
//  - v_o: set on acc; cleared on (v_o & ready_i & ~acc); held during hold. data_o/last_o frozen while hold.
//  - Counters advance only on acc. c wraps IMG_W-1 -> 0 with r+1. At (IMG_H-1, IMG_W-1): r,c -> 0,0 (next frame).
//  - last_o is registered with data_o: 1 iff the accepted pixel was (IMG_H-1, IMG_W-1).
//  - Simultaneous output drain and new accept in the same cycle: data_o is replaced, v_o stays 1 (full throughput).
//  - v_i deasserted mid-row: no state change; the column position is preserved.
//  - Reset mid-frame: counters -> 0, v_o -> 0. The next pixel is treated as (0,0) and its rows above are zero-filled.
//  - No arithmetic on pixel data; counters are $clog2(IMG_W) and $clog2(IMG_H) bits wide, unsigned.
// STRUCTURE
//  - Shared package cnn_pkg:
//      IMG_W, IMG_H, PIX_W constants.
//      typedef pixel_t (logic [PIX_W-1:0]), col_t, row_t, typedef pix_col_t ([2:0] pixel_t).
//  - Sub-module line_mem: depth IMG_W, width PIX_W; synchronous write, combinational read at the same address.
//  - Instantiated twice (lb1, lb2); chained as lb1 read data -> lb2 write data.
//  - Top level holds the counters, the handshake logic and the output register.
// TESTING
//  1 reset: hold reset_i=1 for 2 cycles -> v_o=0, data_o=0, last_o=0; ready_o=1 after release.
//  2 row 0: feed pix 0x11 at (0,5) -> next cycle v_o=1, data_o={0x00,0x00,0x11}.
//  3 pattern pix=(r+c)&0xFF over 3 rows: at (2,3) -> data_o={8'd3,8'd4,8'd5}.
//    At (1,639) -> data_o={0x00,8'd127,8'd128}, since (0+639)&0xFF=127 and (1+639)&0xFF=128.
//  4 backpressure: ready_i=0 for 5 cycles with v_i=1 -> ready_o=0, data_o stable, counters frozen.
//    Then ready_i=1 -> the next pixel is accepted in that cycle; no pixel is lost or duplicated.
//  5 end of frame: stream a full 640x480 frame -> last_o=1 only on beat 307200.
//    The following pixel outputs {0,0,pix}, i.e. (0,0) of the next frame with zero fill.
//  6 reset mid-frame at (10,20) -> the next accepted pixel outputs {0,0,pix}; last_o at 307200 beats after reset.

Source files
------------

// File: rtl/line_buffer_3row_pkg.sv
// Shared constants and types for the 3x3 convolution front end.
// Both line_buffer_3row and the conv unit take the frame geometry from here.
package cnn_pkg;

    // Counter width that never collapses to zero bits for a dimension of 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IMG_W  = 640;
    localparam int IMG_H  = 480;
    localparam int PIX_W  = 8;
    localparam int N_TAPS = 3;
    localparam int COL_W  = cnt_width(IMG_W);
    localparam int ROW_W  = cnt_width(IMG_H);

    typedef logic [PIX_W-1:0] pixel_t;
    typedef logic [COL_W-1:0] col_t;
    typedef logic [ROW_W-1:0] row_t;
    typedef pixel_t [N_TAPS-1:0] pix_col_t;

endpackage

// File: rtl/line_buffer_3row_if.sv
// Pixel-in / column-out stream bundle of the line buffer.
// slave is the line buffer's view, master is the view of whatever drives and drains it.
interface line_buffer_3row_if;
    import cnn_pkg::*;

    pixel_t   pix_i;
    logic     v_i;
    logic     ready_o;
    pix_col_t data_o;
    logic     v_o;
    logic     ready_i;
    logic     last_o;

    modport slave (
        input  pix_i, v_i, ready_i,
        output ready_o, data_o, v_o, last_o
    );

    modport master (
        output pix_i, v_i, ready_i,
        input  ready_o, data_o, v_o, last_o
    );
endinterface

// File: rtl/line_buffer_3row_line_mem.sv
// One row of pixel storage: synchronous write, combinational read at the same address,
// so a read and a write to the same column in one cycle return the old contents.
module line_mem
    import cnn_pkg::*;
#(
    parameter  int DEPTH = IMG_W,
    parameter  int WIDTH = PIX_W,
    localparam int AW    = cnt_width(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_reg [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem_reg[addr] <= wdata;
        end
    end

    assign rdata = mem_reg[addr];

endmodule

// File: rtl/line_buffer_3row.sv
// Turns a raster pixel stream into vertical 3-pixel columns (row r, r-1, r-2) at one column
// per accepted pixel, with rows above the frame top forced to zero.
module line_buffer_3row
    import cnn_pkg::cnt_width;
#(
    parameter int IMG_W = cnn_pkg::IMG_W,
    parameter int IMG_H = cnn_pkg::IMG_H,
    parameter int PIX_W = cnn_pkg::PIX_W
) (
    input  logic               clk_i,
    input  logic               reset_i,
    line_buffer_3row_if.slave  lb
);

    localparam int CW = cnt_width(IMG_W);
    localparam int RW = cnt_width(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]            col_reg, col_next;
    logic [RW-1:0]            row_reg, row_next;
    logic [2:0][PIX_W-1:0]    data_reg, column;
    logic                     v_reg, v_next;
    logic                     last_reg, at_last;
    logic                     ready, acc, mem_we;
    logic [PIX_W-1:0]         lb1_rdata, lb2_rdata;
    logic [PIX_W-1:0]         tap [3];

    // Single output register without skid buffer: room exists when empty or draining now.
    assign ready  = ~v_reg | lb.ready_i;
    assign acc    = lb.v_i & ready;
    assign mem_we = acc & ~reset_i;

    // lb1 holds row r-1; its old value shifts into lb2, which then holds row r-2.
    line_mem #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk_i (clk_i),
        .we    (mem_we),
        .addr  (col_reg),
        .wdata (lb.pix_i),
        .rdata (lb1_rdata)
    );

    line_mem #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb2 (
        .clk_i (clk_i),
        .we    (mem_we),
        .addr  (col_reg),
        .wdata (lb1_rdata),
        .rdata (lb2_rdata)
    );

    assign tap[0] = lb.pix_i;
    assign tap[1] = lb1_rdata;
    assign tap[2] = lb2_rdata;

    // Tap gi looks gi rows up; memory contents are not reset, so rows above the frame top read as zero.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_tap
            if (gi == 0) begin : g_cur
                assign column[gi] = tap[gi];
            end else begin : g_above
                assign column[gi] = (int'(row_reg) >= gi) ? tap[gi] : '0;
            end
        end
    endgenerate

    assign at_last = (row_reg == ROW_LAST) && (col_reg == COL_LAST);

    always_comb begin
        col_next = col_reg;
        row_next = row_reg;
        if (acc) begin
            if (col_reg == COL_LAST) begin
                col_next = '0;
                row_next = (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
            end else begin
                col_next = col_reg + 1'b1;
            end
        end
    end

    assign v_next = acc | (v_reg & ~lb.ready_i);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            col_reg  <= '0;
            row_reg  <= '0;
            v_reg    <= 1'b0;
            data_reg <= '0;
            last_reg <= 1'b0;
        end else begin
            col_reg <= col_next;
            row_reg <= row_next;
            v_reg   <= v_next;
            if (acc) begin
                data_reg <= column;
                last_reg <= at_last;
            end
        end
    end

    assign lb.ready_o = ready;
    assign lb.data_o  = data_reg;
    assign lb.v_o     = v_reg;
    assign lb.last_o  = last_reg;

endmodule

// File: tb/tb_line_buffer_3row.sv
// Bench for line_buffer_3row: random pixels and handshakes against a frame-image reference model.
// Image height is reduced so that whole frames fit in a short run; the row width stays 640.
module tb_line_buffer_3row;
    import cnn_pkg::*;

    localparam int TB_W  = 640;
    localparam int TB_H  = 12;
    localparam int FRAME = TB_W * TB_H;

    logic clk_i = 1'b0;
    logic reset_i;
    always #5 clk_i = ~clk_i;

    line_buffer_3row_if bus();

    line_buffer_3row #(.IMG_W(TB_W), .IMG_H(TB_H), .PIX_W(PIX_W)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .lb      (bus)
    );

    // Reference model: the frame as a 2-D image plus the raster index of the next pixel.
    pixel_t img [TB_H][TB_W];
    int     pidx;
    int     passed = 0;
    int     total  = 0;

    task automatic model_accept(input pixel_t p, output pix_col_t ed, output logic el);
        int r, c;
        r = pidx / TB_W;
        c = pidx % TB_W;
        ed = '0;
        ed[0] = p;
        if (r >= 1) ed[1] = img[r-1][c];
        if (r >= 2) ed[2] = img[r-2][c];
        img[r][c] = p;
        pidx = pidx + 1;
        el = (pidx == FRAME);
        if (el) pidx = 0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present one pixel with the output side open, so it is accepted on the next edge.
    task automatic send(input pixel_t p, output pix_col_t ed, output logic el);
        bus.pix_i   = p;
        bus.v_i     = 1'b1;
        bus.ready_i = 1'b1;
        model_accept(p, ed, el);
        tick();
        bus.v_i = 1'b0;
    endtask

    task automatic do_reset();
        reset_i     = 1'b1;
        bus.v_i     = 1'b0;
        bus.ready_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
        pidx    = 0;
    endtask

    task automatic test_reset();
        reset_i     = 1'b1;
        bus.v_i     = 1'b1;
        bus.pix_i   = pixel_t'($urandom);
        bus.ready_i = 1'b0;
        tick();
        tick();
        total++;
        if (bus.v_o !== 1'b0 || bus.data_o !== '0 || bus.last_o !== 1'b0)
            $display("FAIL reset_outputs v_o=%b data_o=%h last_o=%b expected 0/000000/0",
                     bus.v_o, bus.data_o, bus.last_o);
        else passed++;
        reset_i = 1'b0;
        bus.v_i = 1'b0;
        #1;
        total++;
        if (bus.ready_o !== 1'b1) $display("FAIL reset_ready ready_o=%b expected 1", bus.ready_o);
        else passed++;
        pidx = 0;
        $display("test_reset done");
    endtask

    task automatic test_row0();
        pix_col_t ed, lit;
        logic el;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            send(pixel_t'($urandom), ed, el);
            total++;
            if (bus.data_o !== ed) $display("FAIL row0_lead c=%0d data_o=%h expected %h", c, bus.data_o, ed);
            else passed++;
        end
        send(8'h11, ed, el);
        lit = {8'h00, 8'h00, 8'h11};
        total++;
        if (bus.v_o !== 1'b1 || bus.data_o !== lit || bus.last_o !== 1'b0)
            $display("FAIL row0_pix v_o=%b data_o=%h last_o=%b expected 1/%h/0", bus.v_o, bus.data_o, bus.last_o, lit);
        else passed++;
        $display("test_row0 done");
    endtask

    task automatic test_pattern();
        pix_col_t ed, lit;
        logic el;
        int bad = 0;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < TB_W; c++) begin
                send(pixel_t'((r + c) & 8'hFF), ed, el);
                total++;
                if (bus.data_o !== ed || bus.last_o !== el) begin
                    bad++;
                    if (bad < 10)
                        $display("FAIL pattern r=%0d c=%0d data_o=%h last_o=%b expected %h/%b",
                                 r, c, bus.data_o, bus.last_o, ed, el);
                end else passed++;
                if (r == 2 && c == 3) begin
                    lit = {8'd3, 8'd4, 8'd5};
                    total++;
                    if (bus.data_o !== lit) $display("FAIL pattern_2_3 data_o=%h expected %h", bus.data_o, lit);
                    else passed++;
                end
                if (r == 1 && c == TB_W - 1) begin
                    lit = {8'h00, 8'd127, 8'd128};
                    total++;
                    if (bus.data_o !== lit) $display("FAIL pattern_1_639 data_o=%h expected %h", bus.data_o, lit);
                    else passed++;
                end
            end
        end
        $display("test_pattern done");
    endtask

    task automatic test_backpressure();
        pix_col_t ed, held;
        logic el;
        pixel_t b;
        for (int i = 0; i < 4; i++) begin
            send(pixel_t'($urandom), ed, el);
            total++;
            if (bus.data_o !== ed) $display("FAIL bp_pre i=%0d data_o=%h expected %h", i, bus.data_o, ed);
            else passed++;
        end
        held        = ed;
        b           = pixel_t'($urandom);
        bus.pix_i   = b;
        bus.v_i     = 1'b1;
        bus.ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (bus.ready_o !== 1'b0) $display("FAIL bp_ready cyc=%0d ready_o=%b expected 0", i, bus.ready_o);
            else passed++;
            tick();
            total++;
            if (bus.v_o !== 1'b1 || bus.data_o !== held)
                $display("FAIL bp_hold cyc=%0d v_o=%b data_o=%h expected 1/%h", i, bus.v_o, bus.data_o, held);
            else passed++;
        end
        bus.ready_i = 1'b1;
        #1;
        total++;
        if (bus.ready_o !== 1'b1) $display("FAIL bp_release ready_o=%b expected 1", bus.ready_o);
        else passed++;
        model_accept(b, ed, el);
        tick();
        bus.v_i = 1'b0;
        total++;
        if (bus.v_o !== 1'b1 || bus.data_o !== ed)
            $display("FAIL bp_accept v_o=%b data_o=%h expected 1/%h", bus.v_o, bus.data_o, ed);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            send(pixel_t'($urandom), ed, el);
            total++;
            if (bus.data_o !== ed) $display("FAIL bp_post i=%0d data_o=%h expected %h", i, bus.data_o, ed);
            else passed++;
        end
        $display("test_backpressure done");
    endtask

    // Random valid/ready on both sides until the frame's last pixel has been accepted.
    task automatic test_frame_end();
        pix_col_t ed, lit;
        logic el, exp_v, acc, seen_last;
        int cyc = 0;
        int bad = 0;
        pixel_t p;
        ed = '0;
        el = 1'b0;
        bus.v_i     = 1'b0;
        bus.ready_i = 1'b1;
        tick();
        exp_v     = 1'b0;
        seen_last = 1'b0;
        total++;
        if (bus.v_o !== 1'b0) $display("FAIL fe_drain v_o=%b expected 0", bus.v_o);
        else passed++;
        while (!seen_last && cyc < 40000) begin
            bus.v_i     = ($urandom_range(0, 3) != 0);
            bus.pix_i   = pixel_t'($urandom);
            bus.ready_i = ($urandom_range(0, 3) != 0);
            #1;
            total++;
            if (bus.ready_o !== (!exp_v || bus.ready_i)) begin
                bad++;
                if (bad < 10) $display("FAIL fe_ready cyc=%0d ready_o=%b expected %b",
                                       cyc, bus.ready_o, (!exp_v || bus.ready_i));
            end else passed++;
            acc = bus.v_i && (!exp_v || bus.ready_i);
            if (acc) begin
                model_accept(bus.pix_i, ed, el);
                seen_last = el;
                exp_v = 1'b1;
            end else if (bus.ready_i) begin
                exp_v = 1'b0;
            end
            tick();
            total++;
            if (bus.v_o !== exp_v || (exp_v && (bus.data_o !== ed || bus.last_o !== el))) begin
                bad++;
                if (bad < 10) $display("FAIL fe_stream cyc=%0d v_o=%b data_o=%h last_o=%b expected %b/%h/%b",
                                       cyc, bus.v_o, bus.data_o, bus.last_o, exp_v, ed, el);
            end else passed++;
            cyc++;
        end
        total++;
        if (!seen_last) $display("FAIL fe_timeout cycles=%0d last beat not reached", cyc);
        else passed++;
        p = pixel_t'($urandom);
        send(p, ed, el);
        lit = {8'h00, 8'h00, p};
        total++;
        if (bus.data_o !== lit || bus.last_o !== 1'b0)
            $display("FAIL fe_next_frame data_o=%h last_o=%b expected %h/0", bus.data_o, bus.last_o, lit);
        else passed++;
        $display("test_frame_end done cycles=%0d", cyc);
    endtask

    task automatic test_reset_midframe();
        pix_col_t ed, lit;
        logic el;
        pixel_t p;
        int bad = 0;
        int nlast = 0;
        int last_beat = -1;
        do_reset();
        while (pidx != 10 * TB_W + 20) begin
            send(pixel_t'($urandom), ed, el);
            total++;
            if (bus.data_o !== ed) begin
                bad++;
                if (bad < 10) $display("FAIL rm_pre idx=%0d data_o=%h expected %h", pidx, bus.data_o, ed);
            end else passed++;
        end
        reset_i     = 1'b1;
        bus.v_i     = 1'b1;
        bus.pix_i   = pixel_t'($urandom);
        bus.ready_i = 1'b1;
        tick();
        reset_i = 1'b0;
        bus.v_i = 1'b0;
        pidx    = 0;
        total++;
        if (bus.v_o !== 1'b0 || bus.data_o !== '0)
            $display("FAIL rm_reset v_o=%b data_o=%h expected 0/000000", bus.v_o, bus.data_o);
        else passed++;
        for (int beat = 1; beat <= FRAME + 1; beat++) begin
            p = pixel_t'($urandom);
            send(p, ed, el);
            total++;
            if (bus.data_o !== ed || bus.last_o !== el) begin
                bad++;
                if (bad < 10) $display("FAIL rm_stream beat=%0d data_o=%h last_o=%b expected %h/%b",
                                       beat, bus.data_o, bus.last_o, ed, el);
            end else passed++;
            if (bus.last_o === 1'b1) begin
                nlast++;
                last_beat = beat;
            end
            if (beat == 1) begin
                lit = {8'h00, 8'h00, p};
                total++;
                if (bus.data_o !== lit) $display("FAIL rm_first data_o=%h expected %h", bus.data_o, lit);
                else passed++;
            end
        end
        total++;
        if (nlast != 1 || last_beat != FRAME)
            $display("FAIL rm_last_beat count=%0d beat=%0d expected 1/%0d", nlast, last_beat, FRAME);
        else passed++;
        $display("test_reset_midframe done");
    endtask

    initial begin
        reset_i     = 1'b1;
        bus.pix_i   = '0;
        bus.v_i     = 1'b0;
        bus.ready_i = 1'b1;
        pidx        = 0;
        test_reset();
        test_row0();
        test_pattern();
        test_backpressure();
        test_frame_end();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
